// File: rtl/sys_bus_pkg.sv
// Shared definitions for the serial system bus: field widths, the
// master_out_port FSM state encodings and a burst-decode helper.
`timescale 1ns/1ps
package sys_bus_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int BURST_W = 13;

  // master_out_port FSM encodings (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_READY = 3'd1;
  localparam logic [2:0] ST_HEADER     = 3'd2;
  localparam logic [2:0] ST_GAP        = 3'd3;
  localparam logic [2:0] ST_BEAT       = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  // A request carries extra data beats only for a write with the burst
  // enable set and a beat count above one (count 0 or 1 is a single transfer).
  function automatic logic burst_multi(input logic wr, input logic [BURST_W-1:0] b);
    return wr && b[0] && (b[BURST_W-1:1] > 12'd1);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register: parallel load has priority over
// shift, shifts right filling with 0, LSB is the serial output.
`timescale 1ns/1ps
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sr;

  // Load or shift the register; an exhausted register drains to all zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {1'b0, sr[WIDTH-1:1]};
  end

  assign dout = sr[0];

endmodule

// File: rtl/master_out_port.sv
// Bus-master transmit port: accepts one read/write request (with optional
// write burst) and serializes address, data and burst field LSB-first behind
// the master_valid/slave_ready handshake.
// Optional build macro: MASTER_OUT_TIMEOUT_EN adds a WAIT_READY timeout that
// aborts the request and pulses tx_err.
`timescale 1ns/1ps
module master_out_port
  import sys_bus_pkg::*;
#(
  parameter int BURST_GAP      = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_data,
  input  logic [BURST_W-1:0] req_burst,
  output logic               wdata_req,
  input  logic               slave_ready,
  output logic               master_valid,
  output logic               read_en,
  output logic               write_en,
  output logic               tx_address,
  output logic               tx_data,
  output logic               tx_burst,
  output logic               tx_done,
  output logic               tx_err
);

  localparam logic [3:0] GAP_LAST = (BURST_GAP == 0) ? 4'd0 : 4'(BURST_GAP - 1);

  logic [2:0]  state, state_nxt;
  logic [3:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic [11:0] beat_cnt;
  logic        multi;
  logic        timeout;

  logic accept, hs, header_last, beat_last, gap_last, chain;
  logic shift_hdr, shift_data, load_data;
  logic [DATA_W-1:0] data_din;
  logic addr_bit, data_bit, burst_bit;

  assign accept      = (state == ST_IDLE) && req_valid;
  assign hs          = (state == ST_WAIT_READY) && slave_ready;
  assign header_last = (state == ST_HEADER) && (bit_cnt == 4'd12);
  assign beat_last   = (state == ST_BEAT) && (bit_cnt == 4'd7);
  assign gap_last    = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  // With no gap, the next byte is fetched during bit 7 and loaded on the
  // edge that would otherwise shift bit 7 out, giving back-to-back beats.
  assign chain       = (BURST_GAP == 0) && beat_last && (beat_cnt != 12'd1);

  assign wdata_req  = gap_last || chain;
  assign shift_hdr  = hs || (state == ST_HEADER);
  assign shift_data = shift_hdr || (state == ST_BEAT);
  assign load_data  = accept || wdata_req;
  assign data_din   = (accept && !req_write) ? '0 : req_data;

  piso_shift #(.WIDTH(ADDR_W)) u_addr (
    .clk(clk), .reset(reset), .load(accept), .shift(shift_hdr),
    .din(req_addr), .dout(addr_bit)
  );

  piso_shift #(.WIDTH(DATA_W)) u_data (
    .clk(clk), .reset(reset), .load(load_data), .shift(shift_data),
    .din(data_din), .dout(data_bit)
  );

  piso_shift #(.WIDTH(BURST_W)) u_burst (
    .clk(clk), .reset(reset), .load(accept), .shift(shift_hdr),
    .din(req_burst), .dout(burst_bit)
  );

`ifdef MASTER_OUT_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout = (state == ST_WAIT_READY) && !slave_ready &&
                   (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting for the slave; cleared in every other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        wait_cnt <= '0;
    else if (state == ST_WAIT_READY)  wait_cnt <= wait_cnt + 8'd1;
    else                              wait_cnt <= '0;
  end

  // One-cycle abort indication in the first IDLE cycle after a timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_err <= 1'b0;
    else       tx_err <= timeout;
  end
`else
  assign timeout = 1'b0;
  // TIMEOUT_CYCLES only has meaning when the timeout is built in.
  assign tx_err  = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state decode for the transfer sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (req_valid) state_nxt = ST_WAIT_READY;
      ST_WAIT_READY: begin
        if (slave_ready)  state_nxt = ST_HEADER;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_HEADER:     if (bit_cnt == 4'd12) state_nxt = multi ? ST_GAP : ST_DONE;
      ST_GAP:        if (gap_cnt == GAP_LAST) state_nxt = ST_BEAT;
      ST_BEAT: begin
        if (bit_cnt == 4'd7) begin
          if (beat_cnt == 12'd1)    state_nxt = ST_DONE;
          else if (BURST_GAP == 0)  state_nxt = ST_BEAT;
          else                      state_nxt = ST_GAP;
        end
      end
      ST_DONE:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Bit, gap and beat counters plus the latched burst decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      beat_cnt <= '0;
      multi    <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt <= req_burst[BURST_W-1:1];
        multi    <= burst_multi(req_write, req_burst);
      end else if (header_last || beat_last) begin
        beat_cnt <= beat_cnt - 12'd1;
      end

      if (hs)                        bit_cnt <= 4'd1;
      else if (state == ST_HEADER)   bit_cnt <= header_last ? 4'd0 : bit_cnt + 4'd1;
      else if (state == ST_BEAT)     bit_cnt <= beat_last ? 4'd0 : bit_cnt + 4'd1;

      if (state == ST_GAP) gap_cnt <= gap_last ? 4'd0 : gap_cnt + 4'd1;
      else                 gap_cnt <= '0;
    end
  end

  // Direction strobes: set on accept, dropped when the transfer ends or aborts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_en  <= 1'b0;
      write_en <= 1'b0;
    end else if (accept) begin
      read_en  <= !req_write;
      write_en <= req_write;
    end else if (state_nxt == ST_DONE || state_nxt == ST_IDLE) begin
      read_en  <= 1'b0;
      write_en <= 1'b0;
    end
  end

  assign req_ready    = (state == ST_IDLE);
  assign master_valid = (state == ST_WAIT_READY);
  assign tx_done      = (state == ST_DONE);
  assign tx_address   = addr_bit  && (state == ST_WAIT_READY || state == ST_HEADER);
  assign tx_burst     = burst_bit && (state == ST_WAIT_READY || state == ST_HEADER);
  assign tx_data      = data_bit  && (state == ST_WAIT_READY || state == ST_HEADER ||
                                      state == ST_BEAT);

endmodule

// File: tb/tb_master_out_port.sv
// Self-checking bench for master_out_port: directed scenarios plus random
// requests, each compared cycle-by-cycle against a serial-stream model.
`timescale 1ns/1ps
module tb_master_out_port;

  localparam int TB_GAP     = 1;
  localparam int TB_TIMEOUT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_data = '0;
  logic [12:0] req_burst = '0;
  logic        wdata_req;
  logic        slave_ready = 1'b0;
  logic        master_valid;
  logic        read_en, write_en;
  logic        tx_address, tx_data, tx_burst, tx_done, tx_err;

  int checks = 0;
  int passed = 0;

  // {master_valid, tx_address, tx_data, tx_burst, wdata_req, tx_done, read_en, write_en}
  typedef logic [7:0] vec_t;
  logic [7:0] beat_bytes[$];

  master_out_port #(.BURST_GAP(TB_GAP), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .req_burst(req_burst), .wdata_req(wdata_req), .slave_ready(slave_ready),
    .master_valid(master_valid), .read_en(read_en), .write_en(write_en),
    .tx_address(tx_address), .tx_data(tx_data), .tx_burst(tx_burst),
    .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  // Expected line values per cycle, from the handshake cycle (bit 0) through
  // the tx_done cycle and one idle cycle after it.
  function automatic void build_expected(input logic wr, input logic [11:0] a,
                                         input logic [7:0] d, input logic [12:0] b,
                                         input logic [7:0] bytes[$], output vec_t q[$]);
    int   extra;
    vec_t v;
    q = {};
    extra = (wr && b[0] && b[12:1] > 12'd1) ? int'(b[12:1]) - 1 : 0;
    for (int k = 0; k < 13; k++) begin
      v = '0;
      v[7] = (k == 0);
      v[6] = (k < 12) ? a[k] : 1'b0;
      v[5] = (wr && k < 8) ? d[k] : 1'b0;
      v[4] = b[k];
      v[1] = !wr;
      v[0] = wr;
      q.push_back(v);
    end
    for (int j = 0; j < extra; j++) begin
      for (int g = 0; g < TB_GAP; g++) begin
        v = '0;
        v[3] = (g == TB_GAP - 1);
        v[0] = 1'b1;
        q.push_back(v);
      end
      for (int k = 0; k < 8; k++) begin
        v = '0;
        v[5] = bytes[j][k];
        v[0] = 1'b1;
        q.push_back(v);
      end
    end
    v = '0; v[2] = 1'b1; q.push_back(v);
    v = '0; q.push_back(v);
  endfunction

  // Present a request once the port is idle; returns at the negedge after accept.
  task automatic issue(input logic wr, input logic [11:0] a, input logic [7:0] d,
                       input logic [12:0] b);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      $display("FAIL issue_wait: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d; req_burst = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  // Record line values from the handshake cycle on, feeding burst bytes on wdata_req.
  task automatic capture(input int len, output vec_t obs[$], output bit hs);
    obs = {};
    hs = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (master_valid && slave_ready) begin
        hs = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hs) return;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      obs.push_back({master_valid, tx_address, tx_data, tx_burst,
                     wdata_req, tx_done, read_en, write_en});
      if (wdata_req && beat_bytes.size() > 0) req_data = beat_bytes.pop_front();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({req_ready, wdata_req, master_valid, read_en, write_en, tx_address,
         tx_data, tx_burst, tx_done, tx_err} !== 10'b1000000000)
      $display("FAIL reset_outputs: got %b required 1000000000",
               {req_ready, wdata_req, master_valid, read_en, write_en, tx_address,
                tx_data, tx_burst, tx_done, tx_err});
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    vec_t exp[$], obs[$];
    logic [7:0] none[$];
    bit hs;
    none = {};
    build_expected(1'b1, 12'hA5C, 8'h3B, 13'h000, none, exp);
    slave_ready = 1'b1;
    beat_bytes = {};
    issue(1'b1, 12'hA5C, 8'h3B, 13'h000);
    capture(exp.size(), obs, hs);
    checks++;
    if (!hs) $display("FAIL single_write_handshake: no handshake seen, required one");
    else passed++;
    for (int i = 0; i < exp.size() && hs; i++) begin
      checks++;
      if (obs[i] !== exp[i])
        $display("FAIL single_write cycle %0d: got %b required %b", i, obs[i], exp[i]);
      else passed++;
    end
  endtask

  task automatic test_read_stall();
    vec_t exp[$], obs[$];
    logic [7:0] none[$];
    bit hs;
    none = {};
    build_expected(1'b0, 12'h001, 8'h5A, 13'h000, none, exp);
    slave_ready = 1'b0;
    issue(1'b0, 12'h001, 8'h5A, 13'h000);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({master_valid, tx_address, read_en, write_en, tx_data, tx_err} !== 6'b111000)
        $display("FAIL read_stall cycle %0d: got %b required 111000", i,
                 {master_valid, tx_address, read_en, write_en, tx_data, tx_err});
      else passed++;
    end
    @(negedge clk);
    slave_ready = 1'b1;
    capture(exp.size(), obs, hs);
    checks++;
    if (!hs) $display("FAIL read_handshake: no handshake seen, required one");
    else passed++;
    for (int i = 0; i < exp.size() && hs; i++) begin
      checks++;
      if (obs[i] !== exp[i])
        $display("FAIL read_stream cycle %0d: got %b required %b", i, obs[i], exp[i]);
      else passed++;
    end
  endtask

  task automatic test_burst();
    vec_t exp[$], obs[$];
    logic [7:0] bytes[$];
    bit hs;
    int nreq, ndone;
    bytes = {8'h22, 8'h33};
    build_expected(1'b1, 12'h100, 8'h11, 13'h007, bytes, exp);
    slave_ready = 1'b1;
    beat_bytes = bytes;
    issue(1'b1, 12'h100, 8'h11, 13'h007);
    capture(exp.size(), obs, hs);
    checks++;
    if (!hs) $display("FAIL burst_handshake: no handshake seen, required one");
    else passed++;
    nreq = 0; ndone = 0;
    for (int i = 0; i < exp.size() && hs; i++) begin
      nreq += int'(obs[i][3]);
      ndone += int'(obs[i][2]);
      checks++;
      if (obs[i] !== exp[i])
        $display("FAIL burst_stream cycle %0d: got %b required %b", i, obs[i], exp[i]);
      else passed++;
    end
    checks++;
    if (nreq != 2 || ndone != 1)
      $display("FAIL burst_pulses: got wdata_req=%0d tx_done=%0d required 2 and 1", nreq, ndone);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    slave_ready = 1'b1;
    issue(1'b1, 12'h7FF, 8'hFF, 13'h0FF);
    checks++;
    if (!(master_valid && slave_ready))
      $display("FAIL reset_mid_handshake: master_valid=%b required 1", master_valid);
    else passed++;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, wdata_req, master_valid, read_en, write_en, tx_address,
         tx_data, tx_burst, tx_done, tx_err} !== 10'b1000000000)
      $display("FAIL reset_mid_outputs: got %b required 1000000000",
               {req_ready, wdata_req, master_valid, read_en, write_en, tx_address,
                tx_data, tx_burst, tx_done, tx_err});
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dones += int'(tx_done);
    end
    checks++;
    if (dones != 0 || req_ready !== 1'b1)
      $display("FAIL reset_mid_quiet: got tx_done pulses=%0d req_ready=%b required 0 and 1",
               dones, req_ready);
    else passed++;
  endtask

  task automatic test_busy_ignore();
    vec_t exp[$], obs[$];
    logic [7:0] bytes[$];
    bit hs;
    bytes = {8'h55};
    build_expected(1'b1, 12'h234, 8'h44, 13'h005, bytes, exp);
    slave_ready = 1'b1;
    beat_bytes = bytes;
    issue(1'b1, 12'h234, 8'h44, 13'h005);
    fork
      capture(exp.size(), obs, hs);
      begin
        repeat (16) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) $display("FAIL busy_ready: got %b required 0", req_ready);
        else passed++;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'hFFF;
        @(negedge clk);
        req_valid = 1'b0;
      end
    join
    checks++;
    if (!hs) $display("FAIL busy_handshake: no handshake seen, required one");
    else passed++;
    for (int i = 0; i < exp.size() && hs; i++) begin
      checks++;
      if (obs[i] !== exp[i])
        $display("FAIL busy_stream cycle %0d: got %b required %b", i, obs[i], exp[i]);
      else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, master_valid} !== 2'b10)
        $display("FAIL busy_not_queued cycle %0d: got %b required 10", i,
                 {req_ready, master_valid});
      else passed++;
    end
  endtask

  task automatic test_random();
    vec_t exp[$], obs[$];
    logic [7:0] bytes[$];
    bit hs;
    logic wr;
    logic [11:0] a, cnt;
    logic [7:0] d;
    logic [12:0] b;
    int stall;
    for (int t = 0; t < 12; t++) begin
      wr = 1'($urandom);
      a = 12'($urandom);
      d = 8'($urandom);
      cnt = 12'($urandom_range(0, 4));
      b = {cnt, 1'($urandom)};
      stall = $urandom_range(0, 3);
      bytes = {};
      for (int j = 0; j < 4; j++) bytes.push_back(8'($urandom));
      build_expected(wr, a, d, b, bytes, exp);
      beat_bytes = bytes;
      slave_ready = (stall == 0);
      issue(wr, a, d, b);
      if (stall > 0) begin
        repeat (stall - 1) @(negedge clk);
        slave_ready = 1'b1;
      end
      capture(exp.size(), obs, hs);
      checks++;
      if (!hs) $display("FAIL random_handshake txn %0d: no handshake seen, required one", t);
      else passed++;
      for (int i = 0; i < exp.size() && hs; i++) begin
        checks++;
        if (obs[i] !== exp[i])
          $display("FAIL random txn %0d cycle %0d: got %b required %b", t, i, obs[i], exp[i]);
        else passed++;
      end
    end
  endtask

`ifdef MASTER_OUT_TIMEOUT_EN
  task automatic test_timeout();
    int mv_cycles = 0;
    slave_ready = 1'b0;
    issue(1'b0, 12'h0AA, 8'h00, 13'h000);
    for (int i = 0; i < 40; i++) begin
      if (!master_valid) break;
      mv_cycles++;
      @(negedge clk);
    end
    checks++;
    if (mv_cycles != TB_TIMEOUT || tx_err !== 1'b1 || tx_done !== 1'b0 || master_valid !== 1'b0)
      $display("FAIL timeout_abort: got wait=%0d tx_err=%b tx_done=%b master_valid=%b required %0d 1 0 0",
               mv_cycles, tx_err, tx_done, master_valid, TB_TIMEOUT);
    else passed++;
    @(negedge clk);
    checks++;
    if ({tx_err, req_ready, read_en} !== 3'b010)
      $display("FAIL timeout_after: got %b required 010", {tx_err, req_ready, read_en});
    else passed++;
    slave_ready = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read_stall();
    test_burst();
    test_reset_mid();
    test_busy_ignore();
    test_random();
`ifdef MASTER_OUT_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Run-time bound so a stuck design still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             passed, checks);
    $fatal(1);
  end

endmodule
